// File: rtl/hdlc_tx_framer.sv
// HDLC serial transmitter: start flag, zero-inserted payload, optional FCS, end flag, one bit/Clk.
// Build option: define HDLC_TX_FCS_EN to append a CRC-16 (x^16+x^15+x^2+1, init 0) before the end flag.
module hdlc_tx_framer #(
    parameter int unsigned MAX_BYTES = 126,
    parameter logic [7:0]  FLAG      = 8'h7E,
    parameter logic [7:0]  ABORT_PAT = 8'hFE
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_DataValid,
    input  logic       Tx_LastByte,
    output logic       Tx_Ready,
    input  logic       Tx_AbortFrame,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Done,
    output logic [7:0] Tx_FrameSize
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef HDLC_TX_FCS_EN
        StFcs,
`endif
        StEnd,
        StAbort
    } state_t;

    state_t      state_q, state_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [3:0]  nidx_q, nidx_d;
    logic        last_q, last_d;
    logic [2:0]  ones_q, ones_d;
    logic [7:0]  size_q, size_d;

    logic [7:0]  cur_byte;
    logic [3:0]  cur_idx;
    logic        cur_last;
    logic        do_data;
    logic        go_abort;

`ifdef HDLC_TX_FCS_EN
    logic [15:0] crc_q, crc_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        nidx_d   = nidx_q;
        last_d   = last_q;
        ones_d   = 3'd0;
        size_d   = size_q;
        ready_d  = 1'b0;
`ifdef HDLC_TX_FCS_EN
        crc_d    = crc_q;
`endif
        cur_byte = byte_q;
        cur_idx  = nidx_q;
        cur_last = last_q;
        do_data  = 1'b0;
        go_abort = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (Tx_Enable) begin
                    state_d = StStart;
                    tx_d    = FLAG[0];
                    cnt_d   = 5'd0;
                    size_d  = 8'd0;
`ifdef HDLC_TX_FCS_EN
                    crc_d   = 16'h0000;
`endif
                end
            end
            StStart: begin
                if (Tx_AbortFrame) begin
                    go_abort = 1'b1;
                end else if (cnt_q != 5'd7) begin
                    cnt_d   = cnt_q + 5'd1;
                    tx_d    = FLAG[cnt_d[2:0]];
                    ready_d = (cnt_d == 5'd7);
                end else begin
                    do_data = 1'b1;
                end
            end
            StData: begin
                if (Tx_AbortFrame) begin
                    go_abort = 1'b1;
                end else begin
                    do_data = 1'b1;
                end
            end
`ifdef HDLC_TX_FCS_EN
            StFcs: begin
                if (Tx_AbortFrame) begin
                    go_abort = 1'b1;
                end else if (ones_q == 3'd5) begin
                    tx_d = 1'b0;
                end else if (cnt_q == 5'd16) begin
                    state_d = StEnd;
                    tx_d    = FLAG[0];
                    cnt_d   = 5'd0;
                end else begin
                    tx_d   = crc_q[15];
                    crc_d  = {crc_q[14:0], 1'b0};
                    cnt_d  = cnt_q + 5'd1;
                    ones_d = crc_q[15] ? ones_q + 3'd1 : 3'd0;
                end
            end
`endif
            StEnd: begin
                if (cnt_q != 5'd7) begin
                    cnt_d = cnt_q + 5'd1;
                    tx_d  = FLAG[cnt_d[2:0]];
                end else begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            end
            StAbort: begin
                if (cnt_q != 5'd7) begin
                    cnt_d = cnt_q + 5'd1;
                    tx_d  = ABORT_PAT[cnt_d[2:0]];
                end else begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        // Byte handshake: underrun and overlength both abort; an abort request drops the byte.
        if (do_data && ready_q) begin
            if (!Tx_DataValid || (size_q == 8'(MAX_BYTES))) begin
                go_abort = 1'b1;
            end else begin
                cur_byte = Tx_Data;
                cur_idx  = 4'd0;
                cur_last = Tx_LastByte;
                if (size_q != 8'hFF) begin
                    size_d = size_q + 8'd1;
                end
            end
        end

        if (go_abort) begin
            state_d = StAbort;
            tx_d    = ABORT_PAT[0];
            cnt_d   = 5'd0;
            ones_d  = 3'd0;
        end else if (do_data) begin
            state_d = StData;
            byte_d  = cur_byte;
            last_d  = cur_last;
            nidx_d  = cur_idx;
            if (ones_q == 3'd5) begin
                // Stuffed zero: data shift holds, ones count restarts.
                tx_d   = 1'b0;
                ones_d = 3'd0;
            end else if (cur_idx != 4'd8) begin
                tx_d    = cur_byte[cur_idx[2:0]];
                nidx_d  = cur_idx + 4'd1;
                ones_d  = tx_d ? ones_q + 3'd1 : 3'd0;
                ready_d = (cur_idx == 4'd7) && !cur_last;
`ifdef HDLC_TX_FCS_EN
                crc_d   = crc_step(crc_q, tx_d);
`endif
            end else begin
`ifdef HDLC_TX_FCS_EN
                state_d = StFcs;
                tx_d    = crc_q[15];
                crc_d   = {crc_q[14:0], 1'b0};
                cnt_d   = 5'd1;
                ones_d  = crc_q[15] ? ones_q + 3'd1 : 3'd0;
`else
                state_d = StEnd;
                tx_d    = FLAG[0];
                cnt_d   = 5'd0;
                ones_d  = 3'd0;
`endif
            end
        end

        valid_d   = (state_d != StIdle);
        done_d    = (state_d == StEnd) && (cnt_d == 5'd7);
        aborted_d = (state_d == StAbort) && (cnt_d == 5'd7);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= StIdle;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cnt_q     <= 5'd0;
            byte_q    <= 8'd0;
            nidx_q    <= 4'd0;
            last_q    <= 1'b0;
            ones_q    <= 3'd0;
            size_q    <= 8'd0;
`ifdef HDLC_TX_FCS_EN
            crc_q     <= 16'h0000;
`endif
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            nidx_q    <= nidx_d;
            last_q    <= last_d;
            ones_q    <= ones_d;
            size_q    <= size_d;
`ifdef HDLC_TX_FCS_EN
            crc_q     <= crc_d;
`endif
        end
    end

    assign Tx              = tx_q;
    assign Tx_Ready        = ready_q;
    assign Tx_ValidFrame   = valid_q;
    assign Tx_Done         = done_q;
    assign Tx_AbortedTrans = aborted_q;
    assign Tx_FrameSize    = size_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Bench for hdlc_tx_framer: frame table plus random frames against a bit-stream reference model.
// The model follows HDLC_TX_FCS_EN so it matches whichever build is compiled.
module tb_hdlc_tx_framer;

    localparam int unsigned MAX_BYTES = 126;
    localparam logic [7:0]  FLAG_B    = 8'h7E;
    localparam logic [7:0]  ABORT_B   = 8'hFE;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Tx_Enable = 1'b0;
    logic [7:0] Tx_Data = 8'h00;
    logic       Tx_DataValid = 1'b0;
    logic       Tx_LastByte = 1'b0;
    logic       Tx_Ready;
    logic       Tx_AbortFrame = 1'b0;
    logic       Tx;
    logic       Tx_ValidFrame;
    logic       Tx_AbortedTrans;
    logic       Tx_Done;
    logic [7:0] Tx_FrameSize;

    hdlc_tx_framer #(.MAX_BYTES(MAX_BYTES)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Tx_Enable      (Tx_Enable),
        .Tx_Data        (Tx_Data),
        .Tx_DataValid   (Tx_DataValid),
        .Tx_LastByte    (Tx_LastByte),
        .Tx_Ready       (Tx_Ready),
        .Tx_AbortFrame  (Tx_AbortFrame),
        .Tx             (Tx),
        .Tx_ValidFrame  (Tx_ValidFrame),
        .Tx_AbortedTrans(Tx_AbortedTrans),
        .Tx_Done        (Tx_Done),
        .Tx_FrameSize   (Tx_FrameSize)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        int          nbytes;
        logic [31:0] data;       // byte i in data[8*i +: 8]
        bit          last;       // tag final byte with Tx_LastByte
        int          abort_cyc;  // frame bit index during which Tx_AbortFrame is raised, -1 none
        int          exp_size;
        bit          exp_done;
        bit          exp_ab;
    } vec_t;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] src_q[$];
    bit         src_last;
    bit         acc_pend;
    bit         exp_full[$];
    int         byte_end[$];
    bit         pay[$];
    bit         rem[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

`ifdef HDLC_TX_FCS_EN
    // Remainder of pay(x)*x^16 modulo x^16+x^15+x^2+1 by long division.
    function automatic logic [15:0] ref_crc();
        logic [16:0] g;
        logic [15:0] res;
        int          n;
        g   = 17'h18005;
        n   = pay.size();
        rem = pay;
        for (int k = 0; k < 16; k++) rem.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            if (rem[i]) begin
                for (int k = 0; k < 17; k++) rem[i+k] = rem[i+k] ^ g[16-k];
            end
        end
        for (int k = 0; k < 16; k++) res[15-k] = rem[n+k];
        return res;
    endfunction
`endif

    // Full good-frame wire image of src_q, and the stuffed-stream index of each byte's bit 7.
    task automatic build_model();
        bit stuffed[$];
        int ones;
        pay = {};
        byte_end = {};
        exp_full = {};
        foreach (src_q[i]) for (int b = 0; b < 8; b++) pay.push_back(src_q[i][b]);
`ifdef HDLC_TX_FCS_EN
        begin
            logic [15:0] c;
            c = ref_crc();
            for (int b = 15; b >= 0; b--) pay.push_back(c[b]);
        end
`endif
        ones = 0;
        for (int j = 0; j < pay.size(); j++) begin
            stuffed.push_back(pay[j]);
            if ((j % 8 == 7) && (j / 8 < src_q.size())) byte_end.push_back(stuffed.size() - 1);
            ones = pay[j] ? ones + 1 : 0;
            if (ones == 5) begin
                stuffed.push_back(1'b0);
                ones = 0;
            end
        end
        for (int b = 0; b < 8; b++) exp_full.push_back(FLAG_B[b]);
        foreach (stuffed[i]) exp_full.push_back(stuffed[i]);
        for (int b = 0; b < 8; b++) exp_full.push_back(FLAG_B[b]);
    endtask

    // Tx buffer side: present the queue head; a byte seen accepted is popped one negedge later.
    task automatic serve();
        if (acc_pend) begin
            void'(src_q.pop_front());
            acc_pend = 1'b0;
        end
        Tx_DataValid = (src_q.size() > 0);
        Tx_Data      = (src_q.size() > 0) ? src_q[0] : 8'h00;
        Tx_LastByte  = src_last && (src_q.size() == 1);
        acc_pend     = Tx_Ready && Tx_DataValid;
    endtask

    task automatic do_frame(input string nm, input int abort_cyc, input int exp_size,
                            input bit exp_done, input bit exp_ab);
        bit got[$];
        bit expq[$];
        int p, n_ok, cyc, done_idx, ab_idx, mism, run, maxrun;
        bit seen, ended;
        build_model();
        if (abort_cyc >= 0) begin
            p = abort_cyc;
        end else if (!src_last || src_q.size() > MAX_BYTES) begin
            n_ok = (src_q.size() > MAX_BYTES) ? MAX_BYTES : src_q.size();
            p = (n_ok == 0) ? 7 : 8 + byte_end[n_ok-1];
        end else begin
            p = -1;
        end
        if (p < 0) begin
            expq = exp_full;
        end else begin
            for (int i = 0; i <= p; i++) expq.push_back(exp_full[i]);
            for (int b = 0; b < 8; b++) expq.push_back(ABORT_B[b]);
        end

        @(negedge Clk);
        serve();
        Tx_Enable = 1'b1;
        seen = 0; ended = 0; done_idx = -1; ab_idx = -1; cyc = 0;
        while (cyc < 4000) begin
            @(negedge Clk);
            Tx_Enable = 1'b0;
            Tx_AbortFrame = 1'b0;
            serve();
            cyc++;
            if (Tx_ValidFrame) begin
                seen = 1;
                if (Tx_Done) done_idx = got.size();
                if (Tx_AbortedTrans) ab_idx = got.size();
                if (got.size() == abort_cyc) Tx_AbortFrame = 1'b1;
                got.push_back(Tx);
            end else if (seen) begin
                ended = 1;
                break;
            end
        end

        check({nm, " frame_ended"}, int'(ended), 1);
        check({nm, " length"}, got.size(), expq.size());
        mism = -1;
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            if (mism < 0 && got[i] != expq[i]) mism = i;
        end
        check({nm, " first_bad_bit_index"}, mism, -1);
        check({nm, " done_bit_index"}, done_idx, exp_done ? expq.size() - 1 : -1);
        check({nm, " aborted_bit_index"}, ab_idx, exp_ab ? expq.size() - 1 : -1);
        check({nm, " frame_size"}, int'(Tx_FrameSize), exp_size);
        check({nm, " idle_tx_after"}, int'(Tx), 1);
        if (p < 0) begin
            run = 0; maxrun = 0;
            for (int i = 8; i + 8 < got.size(); i++) begin
                run = got[i] ? run + 1 : 0;
                if (run > maxrun) maxrun = run;
            end
            check({nm, " six_ones_inside"}, int'(maxrun > 5), 0);
        end
        src_q.delete();
        acc_pend = 1'b0;
        Tx_DataValid = 1'b0;
        Tx_LastByte = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    vec_t vecs[10];

    initial begin
        int len, ab, sz;
        vecs[0] = '{2, 32'h0000_5500, 1'b1, -1, 2, 1'b1, 1'b0};
        vecs[1] = '{2, 32'h0000_FFFF, 1'b1, -1, 2, 1'b1, 1'b0};
        vecs[2] = '{1, 32'h0000_0001, 1'b1, -1, 1, 1'b1, 1'b0};
        vecs[3] = '{4, 32'h81FF_3CA5, 1'b1, 19, 2, 1'b0, 1'b1};  // abort on bit 3 of byte 2
        vecs[4] = '{1, 32'h0000_0012, 1'b0, -1, 1, 1'b0, 1'b1};  // underrun on byte 2
        vecs[5] = '{2, 32'h0000_3344, 1'b1, 3, 0, 1'b0, 1'b1};   // abort inside start flag
        vecs[6] = '{3, 32'h007E_7E7E, 1'b1, -1, 3, 1'b1, 1'b0};
        vecs[7] = '{0, 32'h0000_0000, 1'b0, -1, 0, 1'b0, 1'b1};  // no first byte
        vecs[8] = '{2, 32'h0000_01F0, 1'b1, -1, 2, 1'b1, 1'b0};  // ones run spans bytes
        vecs[9] = '{1, 32'h0000_00F8, 1'b1, -1, 1, 1'b1, 1'b0};  // stuff right before end

        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            check($sformatf("idle cycle %0d {tx,vf,rdy,done,ab}", i),
                  int'({Tx, Tx_ValidFrame, Tx_Ready, Tx_Done, Tx_AbortedTrans}), 16);
        end
        check("reset frame_size", int'(Tx_FrameSize), 0);

        for (int i = 0; i < 10; i++) begin
            src_last = vecs[i].last;
            for (int b = 0; b < vecs[i].nbytes; b++) src_q.push_back(vecs[i].data[8*b +: 8]);
            do_frame($sformatf("vec%0d", i), vecs[i].abort_cyc, vecs[i].exp_size,
                     vecs[i].exp_done, vecs[i].exp_ab);
        end

        // Overlength: 127 bytes offered, the 127th accept aborts.
        src_last = 1'b1;
        for (int b = 0; b < 127; b++) src_q.push_back(8'(b * 37 + 11));
        do_frame("overlength", -1, MAX_BYTES, 1'b0, 1'b1);

        for (int r = 0; r < 10; r++) begin
            len = $urandom_range(1, 8);
            src_last = 1'b1;
            for (int b = 0; b < len; b++)
                src_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            build_model();
            if ($urandom_range(0, 1) == 1) begin
                ab = $urandom_range(0, 8 + byte_end[len-1]);
                sz = 0;
                for (int b = 0; b < len; b++) begin
                    if (((b == 0) ? 7 : 8 + byte_end[b-1]) < ab) sz++;
                end
                do_frame($sformatf("rand%0d", r), ab, sz, 1'b0, 1'b1);
            end else begin
                do_frame($sformatf("rand%0d", r), -1, len, 1'b1, 1'b0);
            end
        end

        // Reset in the middle of a frame: line idles immediately, no abort, no done.
        src_last = 1'b1;
        src_q.push_back(8'hAA);
        src_q.push_back(8'hBB);
        @(negedge Clk);
        serve();
        Tx_Enable = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge Clk);
            Tx_Enable = 1'b0;
            serve();
        end
        check("midreset valid_before", int'(Tx_ValidFrame), 1);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        src_q.delete();
        acc_pend = 1'b0;
        Tx_DataValid = 1'b0;
        check("midreset tx", int'(Tx), 1);
        check("midreset frame_size", int'(Tx_FrameSize), 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            check($sformatf("midreset idle %0d {tx,vf,rdy,done,ab}", i),
                  int'({Tx, Tx_ValidFrame, Tx_Ready, Tx_Done, Tx_AbortedTrans}), 16);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
